// File: rtl/srdl_counter_bank_if.sv
// Software access port of the counter bank: channel index, read/write strobes,
// write data, registered read data and read-valid pulse.
interface srdl_counter_bank_if #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned AW = $clog2(NCH) + 1;

  logic [AW-1:0]    sw_addr;
  logic             sw_rd;
  logic             sw_wr;
  logic [WIDTH-1:0] sw_wdata;
  logic [WIDTH-1:0] sw_rdata;
  logic             sw_rvalid;

  modport master (
    output sw_addr, sw_rd, sw_wr, sw_wdata,
    input  sw_rdata, sw_rvalid
  );

  modport slave (
    input  sw_addr, sw_rd, sw_wr, sw_wdata,
    output sw_rdata, sw_rvalid
  );
endinterface

// File: rtl/srdl_counter_bank.sv
// Bank of NCH SystemRDL-style counters behind one software access port.
// Each channel steps up/down by a per-channel amount, saturates or wraps,
// pulses overflow/underflow, and raises a sticky upward threshold-crossing status.
// Optional feature macro: SRDL_CNT_SNAPSHOT_EN -- a read of channel 0 snapshots all
// channels into a shadow bank that later reads of channels 1..NCH-1 return.
module srdl_counter_bank #(
  parameter int unsigned NCH       = 4,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned INCRWIDTH = 4,
  parameter int unsigned DECRWIDTH = 4,
  parameter int unsigned RESET     = 0,
  parameter bit          SATURATE  = 1'b1,
  parameter bit          RCLR      = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           incr,
  input  logic [NCH-1:0]           decr,
  input  logic [NCH*INCRWIDTH-1:0] incrvalue,
  input  logic [NCH*DECRWIDTH-1:0] decrvalue,
  input  logic [NCH*WIDTH-1:0]     threshold,
  srdl_counter_bank_if.slave       bus,
  input  logic [NCH-1:0]           intr_en,
  input  logic [NCH-1:0]           intr_clr,
  output logic [NCH-1:0]           intr_status,
  output logic                     intr,
  output logic [NCH-1:0]           overflow,
  output logic [NCH-1:0]           underflow,
  output logic [NCH*WIDTH-1:0]     q
);
  localparam int unsigned AW = $clog2(NCH) + 1;
  // Two guard bits: one for carry above the top, one as sign for borrow below zero.
  localparam int unsigned SW = WIDTH + 2;
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET);

  // A read that coincides with a write never clears anything.
  logic rd_only;
  assign rd_only = bus.sw_rd && !bus.sw_wr;

`ifdef SRDL_CNT_SNAPSHOT_EN
  logic [NCH*WIDTH-1:0] shadow;
  logic                 snap;
  assign snap = bus.sw_rd && (bus.sw_addr == '0);
`endif

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             status_q, status_d;
    logic [WIDTH-1:0] thr;
    logic [SW-1:0]    base, step_up, step_dn, sum;
    logic             wr_hit, clr, set;

    assign thr     = threshold[g*WIDTH +: WIDTH];
    assign wr_hit  = bus.sw_wr && (bus.sw_addr == AW'(g));
`ifdef SRDL_CNT_SNAPSHOT_EN
    assign clr     = RCLR && rd_only && (bus.sw_addr == '0);
`else
    assign clr     = RCLR && rd_only && (bus.sw_addr == AW'(g));
`endif
    // Read-clear replaces the base, so same-cycle count events still land.
    assign base    = clr ? '0 : {2'b00, cnt_q};
    assign step_up = incr[g] ? SW'(incrvalue[g*INCRWIDTH +: INCRWIDTH]) : '0;
    assign step_dn = decr[g] ? SW'(decrvalue[g*DECRWIDTH +: DECRWIDTH]) : '0;
    assign sum     = base + step_up - step_dn;

    // Next count, range flags and threshold crossing.
    always_comb begin
      cnt_d = cnt_q;
      ovf_d = 1'b0;
      unf_d = 1'b0;
      set   = 1'b0;
      if (wr_hit) begin
        cnt_d = bus.sw_wdata;
      end else begin
        if (sum[SW-1]) begin
          unf_d = 1'b1;
          cnt_d = SATURATE ? '0 : sum[WIDTH-1:0];
        end else if (sum[WIDTH]) begin
          ovf_d = 1'b1;
          cnt_d = SATURATE ? '1 : sum[WIDTH-1:0];
        end else begin
          cnt_d = sum[WIDTH-1:0];
        end
        set = (cnt_q < thr) && (cnt_d >= thr);
      end
      status_d = set || (status_q && !intr_clr[g]);
    end

    // Per-channel state registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q    <= RST_VAL;
        ovf_q    <= 1'b0;
        unf_q    <= 1'b0;
        status_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        ovf_q    <= ovf_d;
        unf_q    <= unf_d;
        status_q <= status_d;
      end
    end

`ifdef SRDL_CNT_SNAPSHOT_EN
    logic [WIDTH-1:0] shadow_q;

    // Shadow copy of the pre-update live value, captured on a channel-0 read.
    always_ff @(posedge clk) begin
      if (rst) begin
        shadow_q <= RST_VAL;
      end else if (snap) begin
        shadow_q <= cnt_q;
      end
    end

    assign shadow[g*WIDTH +: WIDTH] = shadow_q;
`endif

    assign q[g*WIDTH +: WIDTH] = cnt_q;
    assign overflow[g]         = ovf_q;
    assign underflow[g]        = unf_q;
    assign intr_status[g]      = status_q;
  end

  assign intr = |(intr_status & intr_en);

  logic [WIDTH-1:0] rd_val;
  logic [WIDTH-1:0] rdata_q;
  logic             rvalid_q;

  // Read mux; out-of-range indices match no channel and read as zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NCH; i++) begin
      if (bus.sw_addr == AW'(i)) begin
`ifdef SRDL_CNT_SNAPSHOT_EN
        rd_val = (i == 0) ? q[i*WIDTH +: WIDTH] : shadow[i*WIDTH +: WIDTH];
`else
        rd_val = q[i*WIDTH +: WIDTH];
`endif
      end
    end
  end

  // Registered read response.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= bus.sw_rd;
      if (bus.sw_rd) begin
        rdata_q <= rd_val;
      end
    end
  end

  assign bus.sw_rdata  = rdata_q;
  assign bus.sw_rvalid = rvalid_q;
endmodule
